mesh_read_responder: RTL and testbench

- Memory-side end of the mesh read path; the counterpart of the mesh write path that fills each node's memory word.
- One instance per mesh node. It accepts routed read-request packets addressed to this node and queues them in a small FIFO.
- For each request it returns a response packet carrying the requester's address and this node's stored word, for routing back through the mesh.
- It also owns the node's local memory word, which the write path updates.

---
 rtl/mesh_read_responder.sv | 139 +++++++++++++
 tb/tb_mesh_read_responder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mesh_read_responder.sv
// Per-node read responder: queues routed read requests and answers each with {src_addr, local word}.
// Optional parity bit on the response MSB when MESH_RESP_PARITY_EN is defined.
module mesh_read_responder #(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 2,
    parameter int WIDTH      = ADDR_WIDTH + DATA_WIDTH,
    parameter int NODE_ID    = 0,
    parameter int DEPTH      = 2,
    parameter int CNT_WIDTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_valid,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    req_valid,
    input  logic [2*ADDR_WIDTH-1:0] req_pkt,
    output logic                    req_ready,
    output logic                    resp_valid,
`ifdef MESH_RESP_PARITY_EN
    output logic [WIDTH:0]          resp_pkt,
`else
    output logic [WIDTH-1:0]        resp_pkt,
`endif
    input  logic                    resp_ready,
    output logic [DATA_WIDTH-1:0]   mem,
    output logic [CNT_WIDTH-1:0]    drop_cnt,
    output logic                    misroute
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] MY_ADDR = ADDR_WIDTH'(NODE_ID);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] fifo [DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W:0]        count;
    logic [PTR_W:0]        count_next;
    logic                  full;
    logic                  empty;
    logic [ADDR_WIDTH-1:0] dst_addr;
    logic [ADDR_WIDTH-1:0] src_addr;
    logic [ADDR_WIDTH-1:0] head;
    logic                  dst_ok;
    logic                  pop;
    logic                  push;
    logic                  drop;
    logic [WIDTH-1:0]      payload;

    assign dst_addr  = req_pkt[2*ADDR_WIDTH-1:ADDR_WIDTH];
    assign src_addr  = req_pkt[ADDR_WIDTH-1:0];
    assign dst_ok    = (dst_addr == MY_ADDR);
    assign empty     = (count == '0);
    assign head      = fifo[rd_ptr];
    assign payload   = {head, mem};
    assign req_ready = ~full;

    // A full queue still takes a request on an edge where the head is popped.
    assign pop  = ~empty && ((state == IDLE) || resp_ready);
    assign push = req_valid && dst_ok && (~full || pop);
    assign drop = req_valid && (~dst_ok || (full && ~pop));

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + 1'b1;
        end else if (pop && !push) begin
            count_next = count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo[wr_ptr] <= src_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            mem        <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            full       <= 1'b0;
            resp_valid <= 1'b0;
            resp_pkt   <= '0;
            drop_cnt   <= '0;
            misroute   <= 1'b0;
        end else begin
            if (wr_valid) begin
                mem <= wr_data;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_next;
            full  <= (count_next == FULL_CNT);
            if (drop && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
            if (req_valid && !dst_ok) begin
                misroute <= 1'b1;
            end

            // Response register samples mem before any same-edge write lands.
            if (pop) begin
`ifdef MESH_RESP_PARITY_EN
                resp_pkt <= {^payload, payload};
`else
                resp_pkt <= payload;
`endif
            end
            case (state)
                IDLE: begin
                    if (pop) begin
                        state      <= HOLD;
                        resp_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    if (resp_ready && !pop) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mesh_read_responder.sv
// Scoreboard bench for mesh_read_responder: stimulus pushes expected responses, a monitor pops and compares.
module tb_mesh_read_responder;
`ifdef MESH_RESP_PARITY_EN
    localparam int PW = 5;
`else
    localparam int PW = 4;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_valid;
    logic [1:0]    wr_data;
    logic          req_valid;
    logic [3:0]    req_pkt;
    logic          req_ready;
    logic          resp_valid;
    logic [PW-1:0] resp_pkt;
    logic          resp_ready;
    logic [1:0]    mem;
    logic [3:0]    drop_cnt;
    logic          misroute;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [PW-1:0] expq [$];

    mesh_read_responder #(
        .ADDR_WIDTH(2),
        .DATA_WIDTH(2),
        .NODE_ID   (2),
        .DEPTH     (2),
        .CNT_WIDTH (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_valid  (wr_valid),
        .wr_data   (wr_data),
        .req_valid (req_valid),
        .req_pkt   (req_pkt),
        .req_ready (req_ready),
        .resp_valid(resp_valid),
        .resp_pkt  (resp_pkt),
        .resp_ready(resp_ready),
        .mem       (mem),
        .drop_cnt  (drop_cnt),
        .misroute  (misroute)
    );

    always #5 clk = ~clk;

    function automatic logic [PW-1:0] exp_pkt(input logic [1:0] src, input logic [1:0] data);
        logic [3:0] p;
        p = {src, data};
`ifdef MESH_RESP_PARITY_EN
        return {^p, p};
`else
        return p;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] dst, input logic [1:0] src);
        req_valid = 1'b1;
        req_pkt   = {dst, src};
    endtask

    // Monitor: every response handshake is compared against the scoreboard head.
    always @(negedge clk) begin
        if (!rst && resp_valid && resp_ready) begin
            checks++;
            if (expq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_resp: got=%0h want=none", resp_pkt);
            end else begin
                logic [PW-1:0] e;
                e = expq.pop_front();
                if (resp_pkt !== e) begin
                    errors++;
                    $display("FAIL resp_pkt: got=%0h want=%0h", resp_pkt, e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout want=finish");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; wr_valid = 1'b0; wr_data = '0;
        req_valid = 1'b0; req_pkt = '0; resp_ready = 1'b1;
        tick(); tick();
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_mem", 32'(mem), 32'd0);
        check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        check("rst_misroute", 32'(misroute), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        rst = 1'b0;

        // Single read with latency check
        wr_valid = 1'b1; wr_data = 2'b11;
        tick();
        wr_valid = 1'b0;
        check("mem_write", 32'(mem), 32'd3);
        send(2'b10, 2'b01); expq.push_back(exp_pkt(2'b01, 2'b11));
        tick();
        req_valid = 1'b0;
        check("latency_not_early", 32'(resp_valid), 32'd0);
        tick();
        check("latency_valid", 32'(resp_valid), 32'd1);
        tick();
        check("single_back_idle", 32'(resp_valid), 32'd0);

        // Backpressure: fill queue + output register, drop a 4th
        resp_ready = 1'b0;
        send(2'b10, 2'b00); expq.push_back(exp_pkt(2'b00, 2'b11));
        tick();
        send(2'b10, 2'b01); expq.push_back(exp_pkt(2'b01, 2'b11));
        tick();
        send(2'b10, 2'b11); expq.push_back(exp_pkt(2'b11, 2'b11));
        tick();
        check("full_req_ready", 32'(req_ready), 32'd0);
        check("held_valid", 32'(resp_valid), 32'd1);
        send(2'b10, 2'b10);
        tick();
        req_valid = 1'b0;
        check("full_drop_cnt", 32'(drop_cnt), 32'd1);
        // Full queue accepts when the same edge pops
        resp_ready = 1'b1;
        send(2'b10, 2'b10); expq.push_back(exp_pkt(2'b10, 2'b11));
        tick();
        req_valid = 1'b0;
        check("full_pop_accept", 32'(drop_cnt), 32'd1);
        check("full_pop_ready_reg", 32'(req_ready), 32'd0);
        tick(); tick(); tick();
        check("drain_idle", 32'(resp_valid), 32'd0);
        check("drain_ready", 32'(req_ready), 32'd1);

        // Misroute
        send(2'b01, 2'b00);
        tick();
        req_valid = 1'b0;
        check("misroute_set", 32'(misroute), 32'd1);
        check("misroute_drop", 32'(drop_cnt), 32'd2);
        tick(); tick();
        check("misroute_no_resp", 32'(resp_valid), 32'd0);
        send(2'b10, 2'b10); expq.push_back(exp_pkt(2'b10, 2'b11));
        tick();
        req_valid = 1'b0;
        tick(); tick();
        check("misroute_sticky", 32'(misroute), 32'd1);

        // Read/write collision
        wr_valid = 1'b1; wr_data = 2'b01;
        tick();
        wr_valid = 1'b0;
        send(2'b10, 2'b11); expq.push_back(exp_pkt(2'b11, 2'b01));
        tick();
        req_valid = 1'b0;
        wr_valid = 1'b1; wr_data = 2'b10;
        tick();
        wr_valid = 1'b0;
        check("collision_mem", 32'(mem), 32'd2);
        tick();
        check("collision_idle", 32'(resp_valid), 32'd0);

        // drop_cnt saturation: 2 + 14 misroutes clamps at 15
        for (int i = 0; i < 14; i++) begin
            send(2'b00, 2'b00);
            tick();
        end
        req_valid = 1'b0;
        check("drop_saturate", 32'(drop_cnt), 32'd15);

        // Reset mid-operation discards queued and held responses
        resp_ready = 1'b0;
        send(2'b10, 2'b01);
        tick();
        send(2'b10, 2'b11);
        tick();
        req_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_valid", 32'(resp_valid), 32'd0);
        check("midrst_pkt", 32'(resp_pkt), 32'd0);
        check("midrst_ready", 32'(req_ready), 32'd1);
        check("midrst_drop", 32'(drop_cnt), 32'd0);
        check("midrst_misroute", 32'(misroute), 32'd0);
        check("midrst_mem", 32'(mem), 32'd0);
        resp_ready = 1'b1;
        tick(); tick();
        check("midrst_no_resp", 32'(resp_valid), 32'd0);

`ifdef MESH_RESP_PARITY_EN
        // Parity: {01,11} -> parity 1 ; {00,00} -> parity 0
        wr_valid = 1'b1; wr_data = 2'b11;
        tick();
        wr_valid = 1'b0;
        send(2'b10, 2'b01); expq.push_back(5'b1_01_11);
        tick();
        req_valid = 1'b0;
        tick(); tick();
        wr_valid = 1'b1; wr_data = 2'b00;
        tick();
        wr_valid = 1'b0;
        send(2'b10, 2'b00); expq.push_back(5'b0_00_00);
        tick();
        req_valid = 1'b0;
        tick(); tick();
`endif

        check("scoreboard_empty", 32'(expq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
